// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    localparam int DEF_DIVIDEND_W = 16;
    localparam int DEF_DIVISOR_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Counter must hold the value DIVIDEND_W itself, hence the +1.
    function automatic int cnt_width(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   i_pr,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W:0]   o_pr,
    output logic                 o_q_bit
);

    localparam int PR_W = DIVISOR_W + 1;

    // One spare bit keeps the compare exact when the shifted value exceeds 2^DIVISOR_W.
    logic [DIVISOR_W+1:0] w_shift;
    logic [DIVISOR_W+1:0] w_div_ext;

    assign w_shift   = {i_pr, i_bit};
    assign w_div_ext = {2'b00, i_divisor};

    // Restore on a failed trial subtraction, otherwise keep the difference.
    always_comb begin
        o_pr    = PR_W'(w_shift);
        o_q_bit = 1'b0;
        if (w_shift >= w_div_ext) begin
            o_pr    = PR_W'(w_shift - w_div_ext);
            o_q_bit = 1'b1;
        end else begin
            o_pr    = PR_W'(w_shift);
            o_q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);

    state_e                r_state;
    logic [DIVIDEND_W-1:0] r_qsr;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVISOR_W:0]    r_pr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_zero;
    logic                  r_busy;
    logic                  r_done;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_dbz;

    logic [DIVISOR_W:0]    w_pr_next;
    logic                  w_q_bit;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_pr      (r_pr),
        .i_bit     (r_qsr[DIVIDEND_W-1]),
        .i_divisor (r_divisor),
        .o_pr      (w_pr_next),
        .o_q_bit   (w_q_bit)
    );

    // FSM, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_qsr       <= {DIVIDEND_W{1'b0}};
            r_divisor   <= {DIVISOR_W{1'b0}};
            r_pr        <= {(DIVISOR_W+1){1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_zero      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= {DIVIDEND_W{1'b0}};
            r_remainder <= {DIVISOR_W{1'b0}};
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // A zero divisor skips iteration; FINISH publishes the preloaded answer.
                        if (divisor == {DIVISOR_W{1'b0}}) begin
                            r_qsr   <= {DIVIDEND_W{1'b1}};
                            r_pr    <= {1'b0, dividend[DIVISOR_W-1:0]};
                            r_zero  <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_qsr     <= dividend;
                            r_divisor <= divisor;
                            r_pr      <= {(DIVISOR_W+1){1'b0}};
                            r_cnt     <= CNT_W'(DIVIDEND_W);
                            r_zero    <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= RUN;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_pr  <= w_pr_next;
                    r_qsr <= {r_qsr[DIVIDEND_W-2:0], w_q_bit};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= FINISH;
                    end else begin
                        r_state <= RUN;
                    end
                end
                FINISH: begin
                    r_quotient  <= r_qsr;
                    r_remainder <= r_pr[DIVISOR_W-1:0];
                    r_dbz       <= r_zero;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed handshake cases plus random and product round-trip checks.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors;
    int          checks;
    int unsigned cyc;

    seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_done: got q=%0d r=%0d z=%0b at cycle %0d, required no done",
                         quotient, remainder, div_by_zero, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
                    errors = errors + 1;
                    $display("FAIL result: got q=%0d r=%0d z=%0b, required q=%0d r=%0d z=%0b",
                             quotient, remainder, div_by_zero, e.q, e.r, e.z);
                end
                checks = checks + 1;
                if (cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL latency: done at cycle %0d, required cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    // Called at a negedge; the following posedge is the start edge.
    task automatic issue(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic ez);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.z   = ez;
        e.cyc = cyc + 1 + ((b == 8'd0) ? 1 : 17);
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic model_issue(input logic [15:0] a, input logic [7:0] b);
        int unsigned ai;
        int unsigned bi;
        ai = a;
        bi = b;
        if (bi == 0) begin
            issue(a, b, 16'hFFFF, a[7:0], 1'b1);
        end else begin
            issue(a, b, 16'(ai / bi), 8'(ai % bi), 1'b0);
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40; k++) begin
            if (done) return;
            @(negedge clk);
        end
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL timeout: done=%0b after 40 cycles, required done=1", done);
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks = checks + 1;
        if (got !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end
    endtask

    task automatic check_zero(input string name);
        checks = checks + 1;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'd0 ||
            remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL %s: got busy=%0b done=%0b q=%0d r=%0d z=%0b, required all zero",
                     name, busy, done, quotient, remainder, div_by_zero);
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  b;
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);

        issue(16'd9000, 8'd200, 16'd45, 8'd0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            check_bit("busy_during_run", busy, 1'b1);
            @(negedge clk);
        end
        check_bit("busy_after_done", busy, 1'b0);
        wait_done();

        issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        wait_done();
        issue(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0);
        wait_done();

        issue(16'd5, 8'd9, 16'd0, 8'd5, 1'b0);
        wait_done();
        issue(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0);
        wait_done();

        issue(16'h04D2, 8'd0, 16'hFFFF, 8'hD2, 1'b1);
        check_bit("busy_div0_a", busy, 1'b0);
        wait_done();
        check_bit("busy_div0_b", busy, 1'b0);
        @(negedge clk);

        issue(16'd40000, 8'd129, 16'd310, 8'd10, 1'b0);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd1;
        divisor  = 8'd1;
        @(negedge clk);
        start    = 1'b0;
        wait_done();
        repeat (25) @(negedge clk);
        checks = checks + 1;
        if (quotient !== 16'd310 || remainder !== 8'd10) begin
            errors = errors + 1;
            $display("FAIL hold: got q=%0d r=%0d, required q=310 r=10", quotient, remainder);
        end

        issue(16'd500, 8'd3, 16'd166, 8'd2, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("reset_midop");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check_bit("busy_after_abort", busy, 1'b0);
        issue(16'd500, 8'd3, 16'd166, 8'd2, 1'b0);
        wait_done();

        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            if (i % 8 == 0) a = 16'($urandom_range(0, 300));
            model_issue(a, b);
            wait_done();
        end

        // Round trip from an 8x8 product: (a*b)/b must give back a with no remainder.
        for (int bi = 1; bi < 256; bi++) begin
            logic [7:0] ai;
            ai = 8'($urandom);
            issue(16'(ai * bi), 8'(bi), {8'd0, ai}, 8'd0, 1'b0);
            wait_done();
        end

        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
